// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared instruction/data memory port, a 12-state sequencer,
// ready-stretched memory states, zero-extended logical immediates and illegal-opcode reporting.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          WAIT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instr_done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTE, S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t      state_r, state_s;
  logic [31:0] pc_r, ir_r, mdr_r, a_r, b_r, alu_out_r;
  logic [31:0] rf_r [32];

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [31:0] imm_sext_s, imm_zext_s;
  logic        ready_s;
  alu_op_t     funct_op_s, alu_op_s;
  logic        funct_ok_s;
  logic [31:0] alu_b_s, alu_y_s;
  logic        req_re_s, req_we_s, done_s, illegal_s;
  logic [31:0] addr_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] rf_wdata_s;
  logic        shamt_unused_s;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      ALU_ADD: alu = x + y;
      ALU_SUB: alu = x - y;
      ALU_AND: alu = x & y;
      ALU_OR:  alu = x | y;
      ALU_SLT: alu = {31'd0, ($signed(x) < $signed(y))};
      default: alu = 32'd0;
    endcase
  endfunction

  assign opcode_s       = ir_r[31:26];
  assign rs_s           = ir_r[25:21];
  assign rt_s           = ir_r[20:16];
  assign rd_s           = ir_r[15:11];
  assign funct_s        = ir_r[5:0];
  assign shamt_unused_s = ^ir_r[10:6];
  assign imm_sext_s     = {{16{ir_r[15]}}, ir_r[15:0]};
  assign imm_zext_s     = {16'd0, ir_r[15:0]};
  assign ready_s        = WAIT_EN ? mem_ready : 1'b1;

  // R-type funct decode; funct_ok_s also feeds the illegal check in DECODE.
  always_comb begin
    funct_op_s = ALU_ADD;
    funct_ok_s = 1'b1;
    case (funct_s)
      6'h20:   funct_op_s = ALU_ADD;
      6'h22:   funct_op_s = ALU_SUB;
      6'h24:   funct_op_s = ALU_AND;
      6'h25:   funct_op_s = ALU_OR;
      6'h2A:   funct_op_s = ALU_SLT;
      default: funct_ok_s = 1'b0;
    endcase
  end

  // ALU operand/op select: register B for R-type, otherwise the opcode's immediate flavour.
  always_comb begin
    alu_op_s = ALU_ADD;
    alu_b_s  = imm_sext_s;
    if (state_r == S_EXECUTE) begin
      alu_op_s = funct_op_s;
      alu_b_s  = b_r;
    end else begin
      case (opcode_s)
        OP_ANDI: begin alu_op_s = ALU_AND; alu_b_s = imm_zext_s; end
        OP_ORI:  begin alu_op_s = ALU_OR;  alu_b_s = imm_zext_s; end
        default: begin alu_op_s = ALU_ADD; alu_b_s = imm_sext_s; end
      endcase
    end
  end

  assign alu_y_s = alu(alu_op_s, a_r, alu_b_s);

  // Sequencer: next state, memory requests, completion pulses and register-file write control.
  always_comb begin
    state_s    = state_r;
    req_re_s   = 1'b0;
    req_we_s   = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    addr_s     = alu_out_r;
    rf_we_s    = 1'b0;
    rf_waddr_s = rt_s;
    rf_wdata_s = alu_out_r;
    case (state_r)
      S_FETCH: begin
        addr_s   = pc_r;
        req_re_s = 1'b1;
        if (ready_s) state_s = S_DECODE;
        else         state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_s)
          OP_RTYPE: begin
            if (funct_ok_s) begin
              state_s = S_EXECUTE;
            end else begin
              illegal_s = 1'b1;
              done_s    = 1'b1;
              state_s   = S_FETCH;
            end
          end
          OP_LW, OP_SW:            state_s = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI: state_s = S_IEXEC;
          OP_BEQ:                  state_s = S_BRANCH;
          OP_J:                    state_s = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            done_s    = 1'b1;
            state_s   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_s == OP_LW) state_s = S_MEMRD;
        else                   state_s = S_MEMWR;
      end
      S_MEMRD: begin
        req_re_s = 1'b1;
        if (ready_s) state_s = S_MEMWB;
        else         state_s = S_MEMRD;
      end
      S_MEMWB: begin
        rf_we_s    = 1'b1;
        rf_wdata_s = mdr_r;
        done_s     = 1'b1;
        state_s    = S_FETCH;
      end
      S_MEMWR: begin
        req_we_s = 1'b1;
        if (ready_s) begin
          done_s  = 1'b1;
          state_s = S_FETCH;
        end else begin
          state_s = S_MEMWR;
        end
      end
      S_EXECUTE: state_s = S_ALUWB;
      S_ALUWB: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = rd_s;
        done_s     = 1'b1;
        state_s    = S_FETCH;
      end
      S_IEXEC: state_s = S_IWB;
      S_IWB: begin
        rf_we_s = 1'b1;
        done_s  = 1'b1;
        state_s = S_FETCH;
      end
      S_BRANCH, S_JUMP: begin
        done_s  = 1'b1;
        state_s = S_FETCH;
      end
      default: state_s = S_FETCH;
    endcase
  end

  // Gating with reset keeps requests and pulses low for the whole reset cycle.
  assign mem_addr   = addr_s;
  assign mem_re     = req_re_s & reset;
  assign mem_we     = req_we_s & reset;
  assign mem_wdata  = b_r;
  assign pc         = pc_r;
  assign instr_done = done_s & reset;
  assign illegal    = illegal_s & reset;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= S_FETCH;
    else        state_r <= state_s;
  end

  // PC and the holding registers IR, MDR, A, B, ALUOut.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r      <= RESET_PC;
      ir_r      <= 32'd0;
      mdr_r     <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      alu_out_r <= 32'd0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (ready_s) begin
            ir_r <= mem_rdata;
            pc_r <= pc_r + 32'd4;
          end
        end
        S_DECODE: begin
          a_r       <= rf_r[rs_s];
          b_r       <= rf_r[rt_s];
          alu_out_r <= pc_r + {imm_sext_s[29:0], 2'b00};
        end
        S_MEMADR, S_EXECUTE, S_IEXEC: alu_out_r <= alu_y_s;
        S_MEMRD: begin
          if (ready_s) mdr_r <= mem_rdata;
        end
        S_BRANCH: begin
          if (a_r == b_r) pc_r <= alu_out_r;
        end
        S_JUMP: pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_r[i] <= 32'd0;
    end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench: programs stores their register results; a monitor checks every completed store.
module tb_mips_multicycle;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_re, mem_we, mem_ready, instr_done, illegal;
  logic [31:0] alt_addr, alt_wdata, alt_pc;
  logic        alt_re, alt_we, alt_done, alt_ill;

  logic [31:0] mem [512];
  logic [31:0] img [512];
  logic        load_now = 1'b0;
  logic        force_low = 1'b0;
  logic        in_win;
  int          wcnt = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ill_cnt = 0;
  int          done_q[$];
  wr_t         exp_q[$];
  wr_t         exp_w;

  always #5 clk = ~clk;

  mips_multicycle u_dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .instr_done(instr_done), .illegal(illegal)
  );

  mips_multicycle #(.RESET_PC(32'h0000_0100), .WAIT_EN(1'b0)) u_alt (
    .clk(clk), .reset(reset), .mem_addr(alt_addr), .mem_re(alt_re), .mem_we(alt_we),
    .mem_wdata(alt_wdata), .mem_rdata(32'h0000_0000), .mem_ready(1'b0), .pc(alt_pc),
    .instr_done(alt_done), .illegal(alt_ill)
  );

  // Memory: two wait states for any access inside [0x50,0x60), none elsewhere.
  assign in_win    = (mem_addr >= 32'h50) && (mem_addr < 32'h60);
  assign mem_ready = force_low ? 1'b0 : (in_win ? (wcnt >= 2) : 1'b1);
  assign mem_rdata = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    if (!reset || !(mem_re || mem_we) || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    cyc <= reset ? cyc + 1 : 0;
  end

  always @(posedge clk) begin
    if (load_now) begin
      for (int i = 0; i < 512; i++) mem[i] <= img[i];
    end else if (reset && mem_we && mem_ready) begin
      mem[mem_addr[10:2]] <= mem_wdata;
    end
  end

  // Monitor: pops the scoreboard on every completed store, logs instr_done cycles.
  always @(negedge clk) begin
    if (reset && mem_we && mem_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL store_unexpected: got addr=%h data=%h, required no store", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data) begin
          n_bad++;
          $display("FAIL store: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, exp_w.addr, exp_w.data);
        end
      end
    end
    if (reset && instr_done) done_q.push_back(cyc + 1);
    if (reset && illegal) ill_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int done_at(input int i);
    return (i < done_q.size()) ? done_q[i] : -1000;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 512; i++) img[i] = 32'hDEAD_BEEF;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    img[addr >> 2] = w;
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  // Cycle k is the k-th clock period after reset is released; sample at its negedge.
  task automatic to_cycle(input int n);
    do @(negedge clk); while (cyc + 1 < n);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    load_now = 1'b1;
    @(negedge clk);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_instr_done", 32'(instr_done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    done_q.delete();
    ill_cnt = 0;
    force_low = 1'b0;
    load_now = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    // Phase 1: ALU/immediate program, then stalled sw/lw and stores of every result.
    clear_img();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd2, 16'd5));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd3, 16'd12));
    put(32'h08, enc_r(5'd2, 5'd3, 5'd4, 6'h20));
    put(32'h0C, enc_r(5'd3, 5'd2, 5'd5, 6'h22));
    put(32'h10, enc_r(5'd2, 5'd3, 5'd6, 6'h2A));
    put(32'h14, enc_i(6'h0C, 5'd3, 5'd7, 16'hFFFF));
    put(32'h18, enc_i(6'h0D, 5'd0, 5'd8, 16'h8000));
    put(32'h1C, enc_i(6'h2B, 5'd0, 5'd4, 16'd84));
    put(32'h20, enc_i(6'h23, 5'd0, 5'd9, 16'd84));
    put(32'h24, enc_i(6'h2B, 5'd0, 5'd9, 16'h0200));
    put(32'h28, enc_i(6'h2B, 5'd0, 5'd5, 16'h0204));
    put(32'h2C, enc_i(6'h2B, 5'd0, 5'd6, 16'h0208));
    put(32'h30, enc_i(6'h2B, 5'd0, 5'd7, 16'h020C));
    put(32'h34, enc_i(6'h2B, 5'd0, 5'd8, 16'h0210));
    put(32'h38, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    put(32'h3C, enc_i(6'h2B, 5'd0, 5'd0, 16'h0214));
    put(32'h40, enc_j(26'h10));
    do_reset();
    expect_store(32'd84, 32'd17);
    expect_store(32'h200, 32'd17);
    expect_store(32'h204, 32'd7);
    expect_store(32'h208, 32'd1);
    expect_store(32'h20C, 32'd12);
    expect_store(32'h210, 32'h0000_8000);
    expect_store(32'h214, 32'd0);
    to_cycle(1);
    chk("first_fetch_addr", mem_addr, 32'h0);
    chk("first_fetch_re", 32'(mem_re), 32'd1);
    chk("reset_pc", pc, 32'h0);
    chk("alt_first_fetch_addr", alt_addr, 32'h100);
    chk("alt_first_fetch_re", 32'(alt_re), 32'd1);
    to_cycle(2);
    chk("pc_after_fetch", pc, 32'h4);
    chk("alt_pc_no_wait", alt_pc, 32'h104);
    chk("alt_illegal_funct0", 32'(alt_ill), 32'd1);
    to_cycle(3);
    chk("alt_second_fetch", alt_addr, 32'h104);
    to_cycle(29);
    chk("done_count_28cyc", 32'(done_q.size()), 32'd7);
    chk("done7_cycle", 32'(done_at(6)), 32'd28);
    for (int c = 32; c <= 34; c++) begin
      to_cycle(c);
      chk("sw_stall_we", 32'(mem_we), 32'd1);
      chk("sw_stall_addr", mem_addr, 32'd84);
      chk("sw_stall_data", mem_wdata, 32'd17);
    end
    to_cycle(80);
    chk("sw_cycles", 32'(done_at(7) - done_at(6)), 32'd6);
    chk("lw_cycles", 32'(done_at(8) - done_at(7)), 32'd7);
    chk("j_cycles", 32'(done_at(16) - done_at(15)), 32'd3);
    chk("p1_stores_left", 32'(exp_q.size()), 32'd0);

    // Phase 2: beq not taken, beq taken, j, beq self-loop.
    clear_img();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd2, 16'd5));
    put(32'h04, enc_i(6'h08, 5'd0, 5'd3, 16'd7));
    for (int k = 0; k < 6; k++) put(32'h08 + 4 * k, enc_i(6'h08, 5'd0, 5'(10 + k), 16'(k + 1)));
    put(32'h20, enc_i(6'h04, 5'd2, 5'd3, 16'hFFFF));
    put(32'h24, enc_i(6'h04, 5'd2, 5'd2, 16'd2));
    put(32'h28, enc_i(6'h2B, 5'd0, 5'd2, 16'h0300));
    put(32'h2C, enc_i(6'h2B, 5'd0, 5'd2, 16'h0300));
    put(32'h30, enc_j(26'h40));
    put(32'h100, enc_i(6'h2B, 5'd0, 5'd2, 16'h0300));
    put(32'h104, enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    do_reset();
    expect_store(32'h300, 32'd5);
    to_cycle(36);
    chk("beq_not_taken_pc", pc, 32'h24);
    chk("beq_not_taken_fetch", mem_addr, 32'h24);
    to_cycle(39);
    chk("beq_taken_pc", pc, 32'h30);
    to_cycle(42);
    chk("j_pc", pc, 32'h100);
    chk("j_fetch", mem_addr, 32'h100);
    to_cycle(49);
    chk("beq_loop_pc", pc, 32'h104);
    to_cycle(52);
    chk("beq_loop_pc_again", pc, 32'h104);
    to_cycle(53);
    chk("beq_nt_cycles", 32'(done_at(8) - done_at(7)), 32'd3);
    chk("beq_t_cycles", 32'(done_at(9) - done_at(8)), 32'd3);
    chk("jump_cycles", 32'(done_at(10) - done_at(9)), 32'd3);
    chk("p2_stores_left", 32'(exp_q.size()), 32'd0);

    // Phase 3: illegal opcode and funct, write to $0.
    clear_img();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd2, 16'd3));
    put(32'h04, 32'hFC42_0000);
    put(32'h08, enc_r(5'd2, 5'd2, 5'd4, 6'h3F));
    put(32'h0C, enc_i(6'h08, 5'd0, 5'd0, 16'd9));
    put(32'h10, enc_i(6'h2B, 5'd0, 5'd0, 16'h0400));
    put(32'h14, enc_i(6'h2B, 5'd0, 5'd2, 16'h0404));
    put(32'h18, enc_j(26'h6));
    do_reset();
    expect_store(32'h400, 32'd0);
    expect_store(32'h404, 32'd3);
    to_cycle(6);
    chk("illegal_op_pulse", 32'(illegal), 32'd1);
    chk("illegal_op_done", 32'(instr_done), 32'd1);
    to_cycle(7);
    chk("after_illegal_pc", pc, 32'h08);
    chk("after_illegal_fetch", mem_addr, 32'h08);
    to_cycle(8);
    chk("illegal_funct_pulse", 32'(illegal), 32'd1);
    to_cycle(25);
    chk("illegal_count", 32'(ill_cnt), 32'd2);
    chk("p3_stores_left", 32'(exp_q.size()), 32'd0);

    // Phase 4: reset while a store is stalled; registers must come back as zero.
    clear_img();
    put(32'h00, enc_i(6'h08, 5'd0, 5'd2, 16'h0055));
    put(32'h04, enc_i(6'h2B, 5'd0, 5'd2, 16'd84));
    put(32'h08, enc_j(26'h2));
    do_reset();
    to_cycle(8);
    chk("stall_we", 32'(mem_we), 32'd1);
    chk("stall_addr", mem_addr, 32'd84);
    force_low = 1'b1;
    to_cycle(10);
    chk("stall_we_held", 32'(mem_we), 32'd1);
    chk("stall_data", mem_wdata, 32'h55);
    clear_img();
    put(32'h00, enc_i(6'h2B, 5'd0, 5'd2, 16'h0500));
    put(32'h04, enc_i(6'h2B, 5'd0, 5'd31, 16'h0504));
    put(32'h08, enc_j(26'h2));
    do_reset();
    expect_store(32'h500, 32'd0);
    expect_store(32'h504, 32'd0);
    to_cycle(1);
    chk("abort_pc", pc, 32'h0);
    chk("abort_fetch", mem_addr, 32'h0);
    to_cycle(12);
    chk("p4_stores_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
